// File: rtl/seq_checker.sv
// seq_checker: verifies a sampled stream follows x[n] = x[n-1] + x[n-2] mod 2^DataBus.
// Self-seeds from two samples, then predicts and compares each sample, resyncing on error.
`default_nettype none

module seq_checker #(
  parameter int DataBus = 32,
  parameter int CntW    = 16
) (
  input  logic               clk_w,
  input  logic               reset_w,
  input  logic               clr_i_w,
  input  logic               valid_i_w,
  input  logic [DataBus-1:0] seq_i_w,
  output logic [DataBus-1:0] expected_o_w,
  output logic               locked_o_w,
  output logic               err_o_w,
  output logic               err_sticky_o_w,
  output logic [CntW-1:0]    match_cnt_o_w,
  output logic [CntW-1:0]    mis_cnt_o_w
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEED1 = 2'd1;
  localparam logic [1:0] TRACK = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [DataBus-1:0] x0_q, x0_d;
  logic [DataBus-1:0] x1_q, x1_d;
  logic               err_q, err_d;
  logic               sticky_q, sticky_d;
  logic [CntW-1:0]    match_q, match_d;
  logic [CntW-1:0]    mis_q, mis_d;
  logic [DataBus-1:0] pred_w;

  // Carry out is dropped on purpose: wrap-around is a legal part of the sequence.
  assign pred_w = x0_q + x1_q;

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    err_d    = 1'b0;
    sticky_d = sticky_q;
    match_d  = match_q;
    mis_d    = mis_q;
    if (clr_i_w) begin
      state_d  = IDLE;
      x0_d     = '0;
      x1_d     = '0;
      sticky_d = 1'b0;
      match_d  = '0;
      mis_d    = '0;
    end else if (valid_i_w) begin
      case (state_q)
        IDLE: begin
          x1_d    = seq_i_w;
          state_d = SEED1;
        end
        SEED1: begin
          x0_d    = x1_q;
          x1_d    = seq_i_w;
          state_d = TRACK;
        end
        TRACK: begin
          if (seq_i_w == pred_w) begin
            x0_d = x1_q;
            x1_d = seq_i_w;
            if (match_q != {CntW{1'b1}}) match_d = match_q + 1'b1;
          end else begin
            // The offending sample becomes the first seed of the resync.
            err_d    = 1'b1;
            sticky_d = 1'b1;
            if (mis_q != {CntW{1'b1}}) mis_d = mis_q + 1'b1;
            x0_d     = '0;
            x1_d     = seq_i_w;
            state_d  = SEED1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_w or negedge reset_w) begin
    if (!reset_w) begin
      state_q  <= IDLE;
      x0_q     <= '0;
      x1_q     <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      match_q  <= '0;
      mis_q    <= '0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      match_q  <= match_d;
      mis_q    <= mis_d;
    end
  end

  assign expected_o_w   = pred_w;
  assign locked_o_w     = (state_q == TRACK);
  assign err_o_w        = err_q;
  assign err_sticky_o_w = sticky_q;
  assign match_cnt_o_w  = match_q;
  assign mis_cnt_o_w    = mis_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_checker.sv
// Bench for seq_checker: a 32/16 instance and an 8/2 instance share one stimulus stream.
`default_nettype none

module tb_seq_checker;

  logic        clk_w = 1'b0;
  logic        reset_w;
  logic        clr_i_w;
  logic        valid_i_w;
  logic [31:0] seq_i_w;

  logic [31:0] a_exp;
  logic        a_lock, a_err, a_stk;
  logic [15:0] a_match, a_mis;
  logic [7:0]  b_exp;
  logic        b_lock, b_err, b_stk;
  logic [1:0]  b_match, b_mis;

  int checks = 0;
  int errors = 0;

  always #5 clk_w = ~clk_w;

  seq_checker #(.DataBus(32), .CntW(16)) u_a (
    .clk_w(clk_w), .reset_w(reset_w), .clr_i_w(clr_i_w), .valid_i_w(valid_i_w),
    .seq_i_w(seq_i_w), .expected_o_w(a_exp), .locked_o_w(a_lock), .err_o_w(a_err),
    .err_sticky_o_w(a_stk), .match_cnt_o_w(a_match), .mis_cnt_o_w(a_mis)
  );

  seq_checker #(.DataBus(8), .CntW(2)) u_b (
    .clk_w(clk_w), .reset_w(reset_w), .clr_i_w(clr_i_w), .valid_i_w(valid_i_w),
    .seq_i_w(seq_i_w[7:0]), .expected_o_w(b_exp), .locked_o_w(b_lock), .err_o_w(b_err),
    .err_sticky_o_w(b_stk), .match_cnt_o_w(b_match), .mis_cnt_o_w(b_mis)
  );

  // Reference model: history of the last two accepted samples (zero-padded),
  // how many samples are in the current seeding run, and the reported counts.
  int              mw[2] = '{32, 8};
  int              mcw[2] = '{16, 2};
  longint unsigned m_old[2], m_new[2], m_match[2], m_mis[2];
  int              m_n[2];
  bit              m_err[2], m_stk[2];

  function automatic longint unsigned lim(int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint unsigned m_pred(int k);
    return (m_old[k] + m_new[k]) & lim(mw[k]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_old[k] = 0; m_new[k] = 0; m_match[k] = 0; m_mis[k] = 0;
      m_n[k] = 0; m_err[k] = 0; m_stk[k] = 0;
    end
  endtask

  task automatic model_edge(bit c, bit v, longint unsigned s);
    longint unsigned sk;
    for (int k = 0; k < 2; k++) begin
      sk = s & lim(mw[k]);
      m_err[k] = 0;
      if (c) begin
        m_old[k] = 0; m_new[k] = 0; m_match[k] = 0; m_mis[k] = 0;
        m_n[k] = 0; m_stk[k] = 0;
      end else if (v) begin
        if (m_n[k] >= 2 && sk != m_pred(k)) begin
          m_err[k] = 1;
          m_stk[k] = 1;
          if (m_mis[k] < lim(mcw[k])) m_mis[k]++;
          m_old[k] = 0;
          m_new[k] = sk;
          m_n[k] = 1;
        end else begin
          if (m_n[k] >= 2 && m_match[k] < lim(mcw[k])) m_match[k]++;
          m_old[k] = m_new[k];
          m_new[k] = sk;
          if (m_n[k] < 2) m_n[k]++;
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a.expected", 64'(a_exp), m_pred(0));
    chk("a.locked", 64'(a_lock), 64'(m_n[0] >= 2));
    chk("a.err", 64'(a_err), 64'(m_err[0]));
    chk("a.sticky", 64'(a_stk), 64'(m_stk[0]));
    chk("a.match", 64'(a_match), m_match[0]);
    chk("a.mis", 64'(a_mis), m_mis[0]);
    chk("b.expected", 64'(b_exp), m_pred(1));
    chk("b.locked", 64'(b_lock), 64'(m_n[1] >= 2));
    chk("b.err", 64'(b_err), 64'(m_err[1]));
    chk("b.sticky", 64'(b_stk), 64'(m_stk[1]));
    chk("b.match", 64'(b_match), m_match[1]);
    chk("b.mis", 64'(b_mis), m_mis[1]);
  endtask

  task automatic cycle(bit c, bit v, logic [31:0] s);
    @(negedge clk_w);
    clr_i_w = c; valid_i_w = v; seq_i_w = s;
    @(posedge clk_w);
    model_edge(c, v, 64'(s));
    #1;
    check_all();
  endtask

  task automatic stream(input int unsigned vals[$]);
    foreach (vals[i]) cycle(1'b0, 1'b1, vals[i]);
  endtask

  initial begin
    int unsigned r;
    logic [31:0] s;
    reset_w = 1'b0; clr_i_w = 1'b0; valid_i_w = 1'b0; seq_i_w = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clk_w);
    reset_w = 1'b1;

    stream('{1, 2, 3, 5, 8, 13});
    chk("tp1.match", 64'(a_match), 64'd4);
    chk("tp1.expected", 64'(a_exp), 64'd21);
    chk("tp1.mis", 64'(a_mis), 64'd0);

    cycle(1'b1, 1'b0, 32'd0);
    stream('{1, 2, 3, 6});
    chk("tp2.errpulse", 64'(a_err), 64'd1);
    chk("tp2.unlocked", 64'(a_lock), 64'd0);
    stream('{9, 15, 24});
    chk("tp2.match", 64'(a_match), 64'd3);
    chk("tp2.mis", 64'(a_mis), 64'd1);
    chk("tp2.sticky", 64'(a_stk), 64'd1);

    cycle(1'b1, 1'b0, 32'd0);
    stream('{144, 233, 121});
    chk("tp3.b_err", 64'(b_err), 64'd0);
    chk("tp3.b_match", 64'(b_match), 64'd1);

    cycle(1'b1, 1'b0, 32'd0);
    stream('{1, 2});
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'hDEAD);
    chk("tp4.hold_exp", 64'(a_exp), 64'd3);
    stream('{3});
    chk("tp4.match", 64'(a_match), 64'd1);

    cycle(1'b1, 1'b1, 32'd99);
    chk("tp5.clr_match", 64'(a_match), 64'd0);
    chk("tp5.clr_locked", 64'(a_lock), 64'd0);
    chk("tp5.clr_exp", 64'(a_exp), 64'd0);
    stream('{5});
    chk("tp5.one_seed", 64'(a_lock), 64'd0);

    cycle(1'b1, 1'b0, 32'd0);
    stream('{1, 1, 2, 3, 5, 8, 13, 21});
    chk("tp6.b_sat", 64'(b_match), 64'd3);
    chk("tp6.a_cnt", 64'(a_match), 64'd6);

    @(posedge clk_w);
    #3;
    reset_w = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("tp6.async_match", 64'(a_match), 64'd0);
    clr_i_w = 1'b0; valid_i_w = 1'b0;
    @(negedge clk_w);
    reset_w = 1'b1;

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        cycle(1'b1, ($urandom_range(0, 1) == 1), $urandom);
      end else if (r < 20) begin
        cycle(1'b0, 1'b0, $urandom);
      end else begin
        if (m_n[0] < 2 || r < 30) s = $urandom;
        else s = 32'(m_pred(0));
        cycle(1'b0, 1'b1, s);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
